mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Initiator side of the word-addressed data memory port: accepts byte-addressed load/store requests from the pipeline's MEM stage and drives the memory's read/write/address/data signals. The memory only does full-word writes, so byte and halfword stores become read-modify-write sequences. Loads are sign- or zero-extended per RV32I funct3. Misaligned or out-of-range accesses are rejected without touching memory.

## Interface
- ADDR_W, 6, memory word-address width (2^ADDR_W words of 32 bits)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low byte/half used for SB/SH)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load result; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid: misaligned, out-of-range or illegal funct3
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable (sampled by memory on clk rising edge)
- mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  memory read data, combinational from mem_addr while mem_read=1

## Operation
- FSM states: IDLE, RD, WR, RSP. Request fields latched on handshake (req_valid & req_ready).
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Anything else is illegal.
- Error check at handshake: illegal funct3; halfword with addr[0]=1; word with addr[1:0]!=0; any of addr[31:ADDR_W+2] set. Error -> RSP with rsp_err=1; no mem_read/mem_write issued.
- IDLE -> RD for loads, SB and SH. IDLE -> WR for SW (no read).
- RD: mem_read=1; mem_rdata registered. Load -> RSP with result extracted by addr[1:0]; sign-extend LB/LH, zero-extend LBU/LHU. SB/SH -> WR.
- WR: mem_write=1; mem_wdata = merged word (registered read word with the addressed byte/half replaced) or req_wdata for SW. Then -> RSP.
- RSP: rsp_valid=1 for exactly one cycle, then -> IDLE. No response backpressure: the pipeline stalls on !req_ready.
- mem_addr holds the latched word address in RD/WR and is 0 otherwise. mem_wdata is 0 outside WR. mem_read and mem_write are never both high.

## Timing
- Reset: state IDLE; req_ready=1; rsp_valid, rsp_err, mem_read, mem_write=0; rsp_rdata, mem_addr, mem_wdata=0.
- Handshake at edge T (cycles are counted from that edge):
  - load: RD in T+1, rsp_valid in T+2
  - SW: WR in T+1, rsp_valid in T+2
  - SB/SH: RD T+1, WR T+2 (memory updated at edge ending T+2), rsp_valid T+3
  - error: rsp_valid+rsp_err in T+1
- req_valid while not IDLE is ignored; the request stays pending until req_ready.
- rsp_rdata and rsp_err are valid only while rsp_valid=1 and read 0 otherwise.
- Reset asserted mid-sequence: everything returns immediately to reset values. A WR cut off before its edge does not write. No response is produced for the aborted request.

## Structure
- Shared package: funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enum.
- One sub-module, mem_align (combinational): load extract/extend and store byte-merge from addr[1:0], funct3 and the read word. The FSM stays in mem_access_unit.

## Test plan
- Memory words 0..2 preloaded with 17, 9, 25. LW addr 0x8 -> rsp_rdata=25, rsp_valid two cycles after the handshake, mem_read high exactly one cycle.
- Word 3 = 0x80FF7F01. LB 0xD -> 0x0000007F; LB 0xE -> 0xFFFFFFFF; LBU 0xF -> 0x00000080; LH 0xE -> 0xFFFF80FF; LHU 0xC -> 0x00007F01.
- SB 0x5 with data 0xAA onto word 1 (=9) -> word 1 = 0x0000AA09 after the WR edge, rsp_valid at T+3. SW 0x4 with 0x12345678 -> no mem_read, rsp_valid at T+2.
- LW 0x2, SH 0x3, funct3=011 and addr 0x100 (ADDR_W=6) -> rsp_err=1 at T+1, memory unchanged, mem_read/mem_write never asserted.
- Back-to-back req_valid held high -> second request accepted only on return to IDLE; req_ready low throughout RD/WR/RSP.
- rst_n pulled low during the WR state of an SB -> mem_write drops immediately, target word unchanged, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: RV32I load/store width codes and the access FSM states.
package mem_access_unit_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response and word-memory port of the access unit.
interface mem_access_unit_if #(parameter int ADDR_W = 6);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read, mem_write, mem_addr, mem_wdata
    );
    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_align.sv
// mem_align: byte-lane extract/extend for loads and read-modify-write merge for SB/SH.
module mem_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] bmask, bdata, hmask, hdata;

    always_comb begin
        b = rword[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? rword[31:16] : rword[15:0];
        bmask = 32'h0000_00FF << {addr_lo, 3'b000};
        bdata = {24'b0, wdata[7:0]} << {addr_lo, 3'b000};
        hmask = addr_lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        hdata = addr_lo[1] ? {wdata[15:0], 16'b0} : {16'b0, wdata[15:0]};
        load_data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
                    funct3 == F3_LH  ? {{16{h[15]}}, h} :
                    funct3 == F3_LW  ? rword :
                    funct3 == F3_LBU ? {24'b0, b} :
                    funct3 == F3_LHU ? {16'b0, h} : 32'b0;
        store_word = funct3 == F3_SB ? (rword & ~bmask) | bdata :
                     funct3 == F3_SH ? (rword & ~hmask) | hdata : wdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store initiator for a word-wide data memory.
// Sub-word stores run as read-modify-write; bad accesses respond with an error and never reach memory.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input logic               clk,
    input logic               rst_n,
    mem_access_unit_if.master bus
);
    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [31:0] wdata_q;
    logic        legal, err;
    logic [31:0] load_data, store_word;

    always_comb begin
        legal = bus.req_we ? (bus.req_funct3 == F3_SB || bus.req_funct3 == F3_SH || bus.req_funct3 == F3_SW)
                           : (bus.req_funct3 == F3_LB || bus.req_funct3 == F3_LH || bus.req_funct3 == F3_LW ||
                              bus.req_funct3 == F3_LBU || bus.req_funct3 == F3_LHU);
        err = !legal ||
              (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
              (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
              (|bus.req_addr[31:ADDR_W+2]);
    end

    // Align sees the live read word so the merge/extract is captured at the end of RD.
    mem_align u_align (
        .addr_lo   (lo_q),
        .funct3    (f3_q),
        .rword     (bus.mem_rdata),
        .wdata     (wdata_q),
        .load_data (load_data),
        .store_word(store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            f3_q          <= 3'b0;
            lo_q          <= 2'b0;
            wdata_q       <= 32'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'b0;
            bus.rsp_err   <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_q          <= bus.req_we;
                    f3_q          <= bus.req_funct3;
                    lo_q          <= bus.req_addr[1:0];
                    wdata_q       <= bus.req_wdata;
                    bus.req_ready <= 1'b0;
                    if (err) begin
                        state         <= RSP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                    end else if (bus.req_we && bus.req_funct3 == F3_SW) begin
                        state         <= WR;
                        bus.mem_write <= 1'b1;
                        bus.mem_addr  <= bus.req_addr[ADDR_W+1:2];
                        bus.mem_wdata <= bus.req_wdata;
                    end else begin
                        state         <= RD;
                        bus.mem_read  <= 1'b1;
                        bus.mem_addr  <= bus.req_addr[ADDR_W+1:2];
                    end
                end
                RD: begin
                    bus.mem_read <= 1'b0;
                    if (!we_q) begin
                        state         <= RSP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= load_data;
                        bus.mem_addr  <= '0;
                    end else begin
                        state         <= WR;
                        bus.mem_write <= 1'b1;
                        bus.mem_wdata <= store_word;
                    end
                end
                WR: begin
                    state         <= RSP;
                    bus.mem_write <= 1'b0;
                    bus.mem_addr  <= '0;
                    bus.mem_wdata <= 32'b0;
                    bus.rsp_valid <= 1'b1;
                end
                RSP: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= 32'b0;
                    bus.req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of loads, RMW stores, error rejection, back-to-back and reset abort.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(6)) bus();
    mem_access_unit #(.ADDR_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [31:0] mem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = 6'd0;
    logic [31:0] pre_data = 32'd0;
    always @(posedge clk)
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr] : 32'b0;

    int checks = 0;
    int fails = 0;
    int lat, nrd, nwr, nboth;
    logic [31:0] rd;
    logic er;

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issues one request and records response latency and memory strobe activity up to the response.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = -1; nrd = 0; nwr = 0; nboth = 0; rd = 32'b0; er = 1'b0;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.mem_read) nrd++;
            if (bus.mem_write) nwr++;
            if (bus.mem_read && bus.mem_write) nboth++;
            if (bus.rsp_valid) begin
                lat = c; rd = bus.rsp_rdata; er = bus.rsp_err;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready); end
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.mem_read, bus.mem_write} !== 4'b0000) begin
            fails++; $display("FAIL reset_strobes: got %b expected 0000", {bus.rsp_valid, bus.rsp_err, bus.mem_read, bus.mem_write}); end
        checks++; if (bus.rsp_rdata !== 32'b0 || bus.mem_wdata !== 32'b0 || bus.mem_addr !== 6'b0) begin
            fails++; $display("FAIL reset_data: rdata %h wdata %h addr %h expected zeros", bus.rsp_rdata, bus.mem_wdata, bus.mem_addr); end
    endtask

    task automatic test_lw;
        do_req(1'b0, 3'b010, 32'h8, 32'h0);
        checks++; if (rd !== 32'd25) begin fails++; $display("FAIL lw_data: got %h expected %h", rd, 32'd25); end
        checks++; if (lat !== 2) begin fails++; $display("FAIL lw_latency: got %0d expected 2", lat); end
        checks++; if (nrd !== 1 || nwr !== 0) begin fails++; $display("FAIL lw_strobes: reads %0d writes %0d expected 1 0", nrd, nwr); end
        checks++; if (er !== 1'b0) begin fails++; $display("FAIL lw_err: got %b expected 0", er); end
    endtask

    task automatic test_loads;
        logic [2:0]  f3 [5] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad [5] = '{32'hD, 32'hE, 32'hF, 32'hE, 32'hC};
        logic [31:0] ex [5] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3[i], ad[i], 32'h0);
            checks++; if (rd !== ex[i] || er !== 1'b0 || lat !== 2) begin
                fails++; $display("FAIL load_%0d: data %h err %b lat %0d expected %h 0 2", i, rd, er, lat, ex[i]); end
        end
    endtask

    task automatic test_sub_store;
        do_req(1'b1, 3'b000, 32'h5, 32'h1234_56AA);
        checks++; if (lat !== 3) begin fails++; $display("FAIL sb_latency: got %0d expected 3", lat); end
        checks++; if (nrd !== 1 || nwr !== 1 || nboth !== 0) begin
            fails++; $display("FAIL sb_strobes: reads %0d writes %0d both %0d expected 1 1 0", nrd, nwr, nboth); end
        checks++; if (mem[1] !== 32'h0000_AA09) begin fails++; $display("FAIL sb_word: got %h expected 0000aa09", mem[1]); end
        checks++; if (er !== 1'b0 || rd !== 32'b0) begin fails++; $display("FAIL sb_rsp: err %b data %h expected 0 0", er, rd); end
        do_req(1'b1, 3'b001, 32'h6, 32'hCAFE_BEEF);
        checks++; if (mem[1] !== 32'hBEEF_AA09 || lat !== 3) begin
            fails++; $display("FAIL sh_word: got %h lat %0d expected beefaa09 3", mem[1], lat); end
    endtask

    task automatic test_sw;
        do_req(1'b1, 3'b010, 32'h4, 32'h1234_5678);
        checks++; if (lat !== 2) begin fails++; $display("FAIL sw_latency: got %0d expected 2", lat); end
        checks++; if (nrd !== 0 || nwr !== 1) begin fails++; $display("FAIL sw_strobes: reads %0d writes %0d expected 0 1", nrd, nwr); end
        checks++; if (mem[1] !== 32'h1234_5678) begin fails++; $display("FAIL sw_word: got %h expected 12345678", mem[1]); end
    endtask

    task automatic test_errors;
        logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3 [4] = '{3'b010, 3'b001, 3'b011, 3'b010};
        logic [31:0] ad [4] = '{32'h2, 32'h3, 32'h0, 32'h100};
        for (int i = 0; i < 4; i++) begin
            do_req(we[i], f3[i], ad[i], 32'hFFFF_FFFF);
            checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'b0 || nrd !== 0 || nwr !== 0) begin
                fails++; $display("FAIL err_%0d: lat %0d err %b data %h reads %0d writes %0d expected 1 1 0 0 0", i, lat, er, rd, nrd, nwr); end
        end
        checks++; if (mem[0] !== 32'd17) begin fails++; $display("FAIL err_mem: got %h expected %h", mem[0], 32'd17); end
    endtask

    task automatic test_back_to_back;
        logic [4:0]  ready_bits = 5'b0;
        int          c1 = -1, c2 = -1;
        logic [31:0] d1 = 32'b0, d2 = 32'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h0;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            ready_bits[c-1] = bus.req_ready;
            if (bus.rsp_valid && c1 < 0) begin c1 = c; d1 = bus.rsp_rdata; end
            else if (bus.rsp_valid) begin c2 = c; d2 = bus.rsp_rdata; end
            if (c == 2) bus.req_addr = 32'h4;
        end
        bus.req_valid = 1'b0;
        checks++; if (ready_bits !== 5'b00100) begin fails++; $display("FAIL b2b_ready: got %b expected 00100", ready_bits); end
        checks++; if (c1 !== 2 || d1 !== 32'd17) begin fails++; $display("FAIL b2b_first: cycle %0d data %h expected 2 %h", c1, d1, 32'd17); end
        checks++; if (c2 !== 5 || d2 !== 32'h1234_5678) begin fails++; $display("FAIL b2b_second: cycle %0d data %h expected 5 12345678", c2, d2); end
    endtask

    task automatic test_reset_abort;
        logic saw = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h9; bus.req_wdata = 32'h55;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_write !== 1'b1) begin fails++; $display("FAIL abort_in_wr: mem_write %b expected 1", bus.mem_write); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_write !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_wdata !== 32'b0) begin
            fails++; $display("FAIL abort_reset: write %b ready %b wdata %h expected 0 1 0", bus.mem_write, bus.req_ready, bus.mem_wdata); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) begin fails++; $display("FAIL abort_rsp: rsp_valid seen %b expected 0", saw); end
        checks++; if (mem[2] !== 32'd25) begin fails++; $display("FAIL abort_mem: got %h expected %h", mem[2], 32'd25); end
        checks++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b expected 1", bus.req_ready); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0; bus.req_addr = 32'b0; bus.req_wdata = 32'b0;
        preload(6'd0, 32'd17);
        preload(6'd1, 32'd9);
        preload(6'd2, 32'd25);
        preload(6'd3, 32'h80FF_7F01);
        test_reset;
        rst_n = 1'b1;
        test_lw;
        test_loads;
        test_sub_store;
        test_sw;
        test_errors;
        test_back_to_back;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
